// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette index type, NES/VGA geometry and line-buffer states.
package ppu_pkg;

  localparam int unsigned PAL_W        = 6;
  localparam int unsigned VGA_W        = 10;
  localparam int unsigned NES_LINE_PIX = 256;
  localparam int unsigned VGA_H_LAST   = 799;
  localparam int unsigned VGA_V_LAST   = 524;
  localparam int unsigned NES_V_FIRST  = 1;
  localparam int unsigned NES_V_LAST   = 240;

  typedef logic [PAL_W-1:0] pal_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } lbuf_state_t;

endpackage

// File: rtl/line_ram_dp.sv
// Simple dual-port line RAM: one write port, one registered read port, no reset.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module line_ram_dp
  import ppu_pkg::*;
#(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pal_idx_t      wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output pal_idx_t      rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  pal_idx_t mem [DEPTH];

  // Write and registered read; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ppu_scanline_buffer.sv
// Ping-pong scanline buffer between the PPU pixel pipeline and the VGA scan-out.
// Ports: clk, reset (async, active-high);
//   pix_valid/pix_idx/pix_ready  producer handshake, one palette index per pixel;
//   frame_start                  producer restarts the current line at pixel 0;
//   hc/vc                        VGA counters; palette_disp_idx aligned to them;
//   line_req                     pulse after a bank swap; overflow/underrun sticky flags.
module ppu_scanline_buffer
  import ppu_pkg::*;
#(
  parameter int unsigned LINE_PIX = NES_LINE_PIX,
  parameter int unsigned H_LAST   = VGA_H_LAST,
  parameter int unsigned V_FIRST  = NES_V_FIRST,
  parameter int unsigned V_LAST   = NES_V_LAST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  pal_idx_t         pix_idx,
  output logic             pix_ready,
  input  logic             frame_start,
  input  logic [VGA_W-1:0] hc,
  input  logic [VGA_W-1:0] vc,
  output pal_idx_t         palette_disp_idx,
  output logic             line_req,
  output logic             overflow,
  output logic             underrun
);

  localparam int unsigned PTR_W  = $clog2(LINE_PIX);
  localparam int unsigned ADDR_W = PTR_W + 1;

  localparam logic [VGA_W-1:0] H_LAST_C   = VGA_W'(H_LAST);
  localparam logic [VGA_W-1:0] V_FIRST_C  = VGA_W'(V_FIRST);
  localparam logic [VGA_W-1:0] V_LAST_C   = VGA_W'(V_LAST);
  localparam logic [VGA_W-1:0] V_WRAP_C   = VGA_W'(VGA_V_LAST);
  localparam logic [VGA_W-1:0] PREF_END_C = VGA_W'(LINE_PIX - 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(LINE_PIX - 1);

  lbuf_state_t      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             rd_bank_q, rd_bank_d;
  logic             overflow_d, underrun_d, line_req_d;
  logic             rd_vld_q;

  logic [VGA_W-1:0]  vc_next;
  logic              swap_pt, pic_line, do_swap, handshake;
  logic [PTR_W-1:0]  wr_slot;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  pal_idx_t          ram_rdata;

  // Swap point: last pixel of a VGA line whose successor carries NES picture.
  always_comb begin
    vc_next  = (vc == V_WRAP_C) ? '0 : vc + VGA_W'(1);
    swap_pt  = (hc == H_LAST_C) && (vc_next >= V_FIRST_C) && (vc_next <= V_LAST_C);
    pic_line = (vc >= V_FIRST_C) && (vc <= V_LAST_C);
    do_swap  = swap_pt && (state_q == FULL);
  end

  // One-cycle prefetch; at the swap point address 0 of the post-swap bank is read.
  always_comb begin
    ram_re    = swap_pt || (pic_line && (hc < PREF_END_C));
    ram_raddr = swap_pt ? {rd_bank_q ^ do_swap, {PTR_W{1'b0}}}
                        : {rd_bank_q, PTR_W'(hc + VGA_W'(1))};
  end

  // Write FSM next state; swap decision uses the registered state, frame_start wins on the write side.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow;
    underrun_d = underrun;
    line_req_d = 1'b0;
    handshake  = pix_valid && (state_q == FILL);
    wr_slot    = frame_start ? '0 : wr_ptr_q;
    ram_we     = handshake;
    ram_waddr  = {~rd_bank_q, wr_slot};

    if (handshake) begin
      wr_ptr_d = wr_slot + PTR_W'(1);
      if (wr_slot == LAST_PTR) state_d = FULL;
    end

    if (pix_valid && (state_q == FULL)) overflow_d = 1'b1;

    if (swap_pt) begin
      if (state_q == FULL) begin
        rd_bank_d  = ~rd_bank_q;
        wr_ptr_d   = '0;
        state_d    = FILL;
        line_req_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end

    if (frame_start) begin
      wr_ptr_d = handshake ? PTR_W'(1) : '0;
      state_d  = FILL;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
      line_req  <= 1'b0;
      pix_ready <= 1'b1;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_bank_q <= rd_bank_d;
      overflow  <= overflow_d;
      underrun  <= underrun_d;
      line_req  <= line_req_d;
      pix_ready <= (state_d == FILL);
      rd_vld_q  <= ram_re;
    end
  end

  // RAM read data is only meaningful inside the picture window; blank it elsewhere.
  assign palette_disp_idx = rd_vld_q ? ram_rdata : '0;

  line_ram_dp #(
    .AW(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(pix_idx),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// Self-checking bench for ppu_scanline_buffer: a line-level reference model feeds a
// scoreboard every cycle, plus a reset-time vector table and directed corner sequences.
module tb_ppu_scanline_buffer;

  logic       clk;
  logic       reset;
  logic       pix_valid;
  logic [5:0] pix_idx;
  logic       pix_ready;
  logic       frame_start;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [5:0] palette_disp_idx;
  logic       line_req;
  logic       overflow;
  logic       underrun;

  ppu_scanline_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .pix_valid       (pix_valid),
    .pix_idx         (pix_idx),
    .pix_ready       (pix_ready),
    .frame_start     (frame_start),
    .hc              (hc),
    .vc              (vc),
    .palette_disp_idx(palette_disp_idx),
    .line_req        (line_req),
    .overflow        (overflow),
    .underrun        (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       lreq;
    logic       ovf;
    logic       und;
    logic       chk_pal;
    logic [5:0] pal;
  } sb_t;

  typedef struct {
    logic [5:0] val;
    bit         fs;
  } pix_t;

  typedef struct {
    int         h;
    int         v;
    bit         pv;
    logic [5:0] idx;
    bit         fs;
    logic       ready;
    logic       lreq;
    logic       ovf;
    logic       und;
    bit         chk_pal;
    logic [5:0] pal;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  sb_t  sb_q[$];
  pix_t prod_q[$];
  int   prod_start = 0;
  int   hold_cnt   = 0;

  // Reference model at line granularity.
  logic [5:0] m_disp [256];
  logic [5:0] m_pend [256];
  bit         m_disp_valid;
  int         m_cnt;
  bit         m_ovf, m_und, m_lreq;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: hc=%0d vc=%0d got %0d expected %0d", nm, hc, vc, act, exp_v);
  endtask

  task automatic model_reset();
    m_disp_valid = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_und = 0;
    m_lreq = 0;
    prod_q.delete();
    sb_q.delete();
    prod_start = 0;
    hold_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_idx = '0;
    frame_start = 1'b0;
    hc = '0;
    vc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check presented outputs against the model, advance the model.
  task automatic step_raw(input int h, input int v, input bit pv, input logic [5:0] pidx,
                          input bit fs, output bit hs, output sb_t obs);
    sb_t e, got;
    bit  in_win, sw;
    int  vn, nxt, base;
    bit  lreq;
    @(negedge clk);
    hc = 10'(h);
    vc = 10'(v);
    pix_valid = pv;
    pix_idx = pidx;
    frame_start = fs;
    in_win = (v >= 1) && (v <= 240) && (h <= 255);
    e.ready = (m_cnt < 256);
    e.lreq = m_lreq;
    e.ovf = m_ovf;
    e.und = m_und;
    e.chk_pal = !(in_win && !m_disp_valid);
    e.pal = in_win ? m_disp[h] : 6'd0;
    sb_q.push_back(e);
    #1;
    obs.ready = pix_ready;
    obs.lreq = line_req;
    obs.ovf = overflow;
    obs.und = underrun;
    obs.chk_pal = 1'b1;
    obs.pal = palette_disp_idx;
    got = sb_q.pop_front();
    chk("pix_ready", obs.ready, got.ready);
    chk("line_req", obs.lreq, got.lreq);
    chk("overflow", obs.ovf, got.ovf);
    chk("underrun", obs.und, got.und);
    if (got.chk_pal) chk("palette_disp_idx", obs.pal, got.pal);

    hs = pv && (m_cnt < 256);
    vn = (v == 524) ? 0 : v + 1;
    sw = (h == 799) && (vn >= 1) && (vn <= 240);
    nxt = m_cnt;
    lreq = 0;
    if (pv && (m_cnt == 256)) m_ovf = 1;
    if (hs) begin
      base = fs ? 0 : m_cnt;
      m_pend[base] = pidx;
      nxt = base + 1;
    end
    if (sw) begin
      if (m_cnt == 256) begin
        m_disp = m_pend;
        m_disp_valid = 1;
        lreq = 1;
        nxt = 0;
      end else begin
        m_und = 1;
      end
    end
    if (fs) nxt = hs ? 1 : 0;
    m_cnt = nxt;
    m_lreq = lreq;
  endtask

  // One clock with the producer fed from prod_q (or held valid for overflow tests).
  task automatic step(input int h, input int v);
    bit pv, fs, hs;
    logic [5:0] pidx;
    sb_t obs;
    pv = 0;
    fs = 0;
    pidx = '0;
    if (prod_q.size() > 0 && h >= prod_start) begin
      pv = 1;
      pidx = prod_q[0].val;
      fs = prod_q[0].fs;
    end else if (hold_cnt > 0) begin
      pv = 1;
      pidx = 6'h3F;
      hold_cnt--;
    end
    step_raw(h, v, pv, pidx, fs, hs, obs);
    if (hs && prod_q.size() > 0 && h >= prod_start) void'(prod_q.pop_front());
  endtask

  task automatic run_line(input int v);
    for (int h = 0; h < 800; h++) step(h, v);
  endtask

  // kind 0: n mod 64, 1: (n+17) mod 64, 2: (5n+1) mod 64, 3: (n+40) mod 64
  task automatic push_pix(input int first, input int count, input int kind);
    pix_t p;
    for (int n = first; n < first + count; n++) begin
      case (kind)
        0: p.val = 6'(n % 64);
        1: p.val = 6'((n + 17) % 64);
        2: p.val = 6'((5 * n + 1) % 64);
        default: p.val = 6'((n + 40) % 64);
      endcase
      p.fs = 0;
      prod_q.push_back(p);
    end
  endtask

  vec_t tbl[5];

  initial begin
    bit  hs;
    sb_t obs;
    pix_t p;
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_idx = '0;
    frame_start = 1'b0;
    hc = '0;
    vc = '0;

    //            h    v   pv idx    fs rdy lrq ovf und chkp pal
    tbl[0] = '{500, 300, 0, 6'd0, 0, 1, 0, 0, 0, 1, 6'd0};
    tbl[1] = '{799,   0, 0, 6'd0, 0, 1, 0, 0, 0, 1, 6'd0};
    tbl[2] = '{  0,   1, 0, 6'd0, 0, 1, 0, 0, 1, 0, 6'd0};
    tbl[3] = '{  1,   1, 1, 6'd5, 0, 1, 0, 0, 1, 0, 6'd0};
    tbl[4] = '{  2,   1, 0, 6'd0, 0, 1, 0, 0, 1, 0, 6'd0};

    // Reset values and the first underrun with an empty write bank.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step_raw(tbl[i].h, tbl[i].v, tbl[i].pv, tbl[i].idx, tbl[i].fs, hs, obs);
      chk("tbl_ready", obs.ready, tbl[i].ready);
      chk("tbl_line_req", obs.lreq, tbl[i].lreq);
      chk("tbl_overflow", obs.ovf, tbl[i].ovf);
      chk("tbl_underrun", obs.und, tbl[i].und);
      if (tbl[i].chk_pal) chk("tbl_palette", obs.pal, tbl[i].pal);
    end

    // Basic fill and scan-out.
    do_reset();
    push_pix(0, 256, 0);
    run_line(0);
    run_line(1);

    // Underrun: partial line repeats previous image, completion swaps next line.
    do_reset();
    push_pix(0, 256, 0);
    run_line(0);
    push_pix(0, 200, 1);
    run_line(1);
    push_pix(200, 56, 1);
    run_line(2);
    run_line(3);

    // Overflow: valid held against a full bank must not corrupt data.
    do_reset();
    push_pix(0, 256, 0);
    run_line(0);
    push_pix(0, 256, 1);
    hold_cnt = 10;
    run_line(1);
    run_line(2);

    // frame_start mid-line together with a pixel.
    do_reset();
    push_pix(0, 100, 3);
    p.val = 6'h2A;
    p.fs = 1;
    prod_q.push_back(p);
    push_pix(0, 255, 2);
    run_line(0);
    run_line(1);

    // Line completed exactly on the swap point: swap deferred by one line.
    do_reset();
    prod_start = 544;
    push_pix(0, 256, 2);
    run_line(0);
    prod_start = 0;
    run_line(1);
    run_line(2);

    // Asynchronous reset in the middle of a picture line.
    do_reset();
    push_pix(0, 256, 0);
    run_line(0);
    run_line(1);
    for (int h = 0; h < 100; h++) step(h, 50);
    @(negedge clk);
    hc = 10'd100;
    vc = 10'd50;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_palette", palette_disp_idx, 0);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_line_req", line_req, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underrun", underrun, 0);
    do_reset();
    push_pix(0, 256, 0);
    run_line(0);
    run_line(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppu_scanline_buffer.md
Name: ppu_scanline_buffer

Overview:
- Ping-pong line buffer between the PPU pixel pipeline (producer) and the VGA timing/palette block (consumer).
- PPU side: pushes 6-bit palette indices with a valid/ready handshake.
- VGA side: the block returns `palette_disp_idx` aligned to the VGA `hc`/`vc` counters.
- Each NES scanline (256 px) is written into one bank while the other bank is scanned out on the matching VGA line.

Parameters:
- `LINE_PIX`, 256, pixels per NES scanline; buffer depth per bank.
- `H_LAST`, 799, last VGA horizontal count.
- `V_FIRST`, 1, first VGA line carrying NES picture.
- `V_LAST`, 240, last VGA line carrying NES picture.

Ports:
- `clk` in 1: system/pixel clock. The VGA counters advance on this clock.
- `reset` in 1: asynchronous, active-high.
- `pix_valid` in 1: producer has a pixel on `pix_idx`.
- `pix_idx` in 6: palette index of the next pixel, left to right.
- `pix_ready` out 1: buffer accepts a pixel this cycle.
- `frame_start` in 1: one-cycle pulse; producer restarts at line 0.
- `hc` in 10: VGA horizontal count.
- `vc` in 10: VGA vertical count.
- `palette_disp_idx` out 6: palette index for the current `hc`/`vc`.
- `line_req` out 1: one-cycle pulse; a bank was released and the producer may fill the next line.
- `overflow` out 1: sticky; a pixel was offered while the write bank was full.
- `underrun` out 1: sticky; a swap point was reached with an incomplete write bank.

Behaviour:
- **Clock and reset:** one clock `clk`. Reset is asynchronous and active-high on `reset`.
- **Reset values:**
  - `palette_disp_idx` = 0, `pix_ready` = 1, `line_req` = 0, `overflow` = 0, `underrun` = 0.
  - `rd_bank` = 0, `wr_ptr` = 0, write FSM = FILL.
  - RAM contents are not reset.
- **Storage:** 2×`LINE_PIX`×6 simple dual-port RAM, addressed `{bank, ptr[7:0]}`. One write port, one registered read port.
- **Write FSM, state FILL:**
  - `pix_ready` = 1.
  - A handshake (`pix_valid` & `pix_ready`) writes `pix_idx` to `{~rd_bank, wr_ptr}` and increments `wr_ptr`.
  - When the write with `wr_ptr` = 255 is accepted, go to FULL.
- **Write FSM, state FULL:**
  - `pix_ready` = 0. No writes occur.
  - `pix_valid` = 1 sets `overflow`.
- **Swap point:** the cycle with `hc` == `H_LAST` and next line (`vc`+1, wrapping 524→0) within `V_FIRST`..`V_LAST`.
  - If FSM is FULL (registered state): toggle `rd_bank`, set `wr_ptr` = 0, go to FILL, pulse `line_req` on the next cycle.
  - If FSM is FILL: no swap; the previous line is repeated; set `underrun`.
- **Same-cycle pixel and swap:** a pixel completing the line on the swap-point cycle is accepted and FSM enters FULL. The swap decision still uses the pre-cycle state, so it counts as an underrun and the swap waits one line.
- **`frame_start`:** sets `wr_ptr` = 0 and FSM = FILL. `rd_bank` and sticky flags are unchanged.
  - If a handshake coincides, the pixel is written at address 0 and `wr_ptr` = 1.
  - `frame_start` has priority over the swap-point write-side update. `rd_bank` still toggles if the pre-cycle state was FULL.
- **Read timing, 1-cycle prefetch:**
  - At `hc` = h with h in 0..254 on a picture line: read `{rd_bank, h+1}`.
  - At a swap-point cycle: read address 0 of the post-swap bank (same-cycle bank select).
  - Result: `palette_disp_idx` equals pixel `hc` of the current line for every `hc` in 0..255 and `vc` in `V_FIRST`..`V_LAST`.
  - Outside that window, the registered output is 0.
- **Widths:** `wr_ptr` is 8 bits and wraps naturally, but wrap is unreachable because FULL blocks writes. All `hc`/`vc` compares are 10-bit unsigned.
- **Sticky flags:** `overflow` and `underrun` clear only on `reset`.
- **Reset mid-line:** all state returns to reset values immediately. The first swap after reset can only occur once a full 256-pixel line has been written.

Decomposition:
- **Shared package `ppu_pkg`:**
  - `pal_idx_t` (logic [5:0]).
  - Constants `NES_LINE_PIX` = 256, `VGA_H_LAST` = 799, `VGA_V_LAST` = 524, `NES_V_FIRST` = 1, `NES_V_LAST` = 240.
  - Enum `lbuf_state_t` {FILL, FULL}.
- **Sub-module `line_ram_dp`:** 512×6, 1 write port, 1 registered read port, no reset. Keeps the inferred block RAM separate.
- **Top module:** FSM, pointers, bank select, read-address generation and flags.

Test Plan:
1. **Basic fill and scan-out:** after reset, push 256 pixels with `pix_idx` = n mod 64, then run VGA to `vc` = 1. Expect `pix_ready` to fall after pixel 255, `line_req` to pulse one cycle after `hc` = 799/`vc` = 0, and `palette_disp_idx` = `hc` mod 64 for `hc` 0..255, then 0 at `hc` 256..799.
2. **Underrun:** push only 200 pixels before the swap point. Expect `underrun` = 1, `rd_bank` unchanged, and the line-1 image repeated on line 2. Completing the 56 remaining pixels makes the next swap succeed.
3. **Overflow:** fill 256 pixels, then hold `pix_valid` = 1 for 10 cycles before the swap. Expect `pix_ready` = 0, `overflow` = 1, and no data corruption (scan-out equals the first 256 values).
4. **`frame_start` mid-line:** after 100 pixels, pulse `frame_start` together with a pixel of value 6'h2A. Expect that pixel stored at address 0, the next 255 pixels at addresses 1..255, and FULL after 256 total.
5. **Same-cycle completion at swap point:** the 256th pixel is handshaken exactly at `hc` = 799/`vc` = 0. Expect `underrun` = 1, no swap on this line, and a swap at the next line's `hc` = 799 with `line_req` pulsing.
6. **Async reset mid-scan:** assert `reset` at `hc` = 100/`vc` = 50. Expect outputs at reset values within the same cycle and `pix_ready` = 1; after release, behaviour matches scenario 1.
